alu_scheduler: RTL and testbench

Shares one registered 4-bit ALU among `NREQ` independent requesters. Each requester offers an operation with a valid/ready handshake. A round-robin arbiter grants one request at a time, and a small FSM sequences the operation through the ALU. The 5-bit result is returned on a single response channel tagged with the requester ID. The block sits between the client engines and the shared `alu`, which it instantiates.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 41 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/alu_scheduler.sv | 105 ++++++++++
 tb/tb_alu_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice: opcodes, datapath widths
// and the sequencing FSM state encoding.
package alu_pkg;

    localparam int DIN_W  = 4;
    localparam int DOUT_W = 5;

    localparam logic [1:0] ADD           = 2'b00;
    localparam logic [1:0] SUB           = 2'b01;
    localparam logic [1:0] NOT_A         = 2'b10;
    localparam logic [1:0] REDUCTIONOR_B = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu.sv
// Registered 4-bit signed ALU producing a 5-bit signed result one cycle
// after its operands are presented.
module alu
    import alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               opcode,
    input  logic signed [DIN_W-1:0]  a,
    input  logic signed [DIN_W-1:0]  b,
    output logic signed [DOUT_W-1:0] c
);

    logic signed [DOUT_W-1:0] a_ext;
    logic signed [DOUT_W-1:0] b_ext;
    logic signed [DOUT_W-1:0] result;

    // Sign-extend first so ADD/SUB never overflow the 5-bit result.
    assign a_ext = {a[DIN_W-1], a};
    assign b_ext = {b[DIN_W-1], b};

    always_comb begin
        result = '0;
        case (opcode)
            ADD:           result = a_ext + b_ext;
            SUB:           result = a_ext - b_ext;
            NOT_A:         result = ~a_ext;
            REDUCTIONOR_B: result = {{(DOUT_W-1){1'b0}}, |b};
            default:       result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c <= '0;
        end else begin
            c <= result;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping, and reports the winner both one-hot and encoded.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic           found;

    // The extra sum bit holds ptr+k before the modulo wrap back into range.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
        if (!en) begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered ALU among NREQ requesters: round-robin accept,
// one EXEC cycle through the ALU, then a tagged response held until taken.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_opcode,
    input  logic [DIN_W*NREQ-1:0] req_a,
    input  logic [DIN_W*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DOUT_W-1:0]     rsp_data,
    output logic [15:0]           ops_done
);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win_idx;
    logic [NREQ-1:0]  gnt;
    logic             accept;
    logic [1:0]       op_code;
    logic [DIN_W-1:0] op_a;
    logic [DIN_W-1:0] op_b;

    logic [1:0]       opcode_arr [NREQ];
    logic [DIN_W-1:0] a_arr      [NREQ];
    logic [DIN_W-1:0] b_arr      [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign opcode_arr[i] = req_opcode[2*i +: 2];
        assign a_arr[i]      = req_a[DIN_W*i +: DIN_W];
        assign b_arr[i]      = req_b[DIN_W*i +: DIN_W];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arbiter (
        .req (req_valid),
        .ptr (ptr),
        .en  (state == IDLE),
        .gnt (gnt),
        .idx (win_idx)
    );

    // The grant only ever covers a valid request, so any grant is an accept.
    assign req_ready = gnt;
    assign accept    = |gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            op_code   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_code <= opcode_arr[win_idx];
                        op_a    <= a_arr[win_idx];
                        op_b    <= b_arr[win_idx];
                        rsp_id  <= win_idx;
                        ptr     <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Op registers hold through RESP, so the ALU keeps recomputing the same value.
    alu u_alu (
        .clk    (clk),
        .reset  (reset),
        .opcode (op_code),
        .a      (op_a),
        .b      (op_b),
        .c      (rsp_data)
    );

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: table-driven single operations plus
// round-robin, back-pressure, mid-operation reset and counter-wrap sequences.
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_opcode;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [4:0]        rsp_data;
    logic [15:0]       ops_done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ops;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [4:0]     data;
    } rsp_t;
    rsp_t expq[$];

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
    } vec_t;
    vec_t vectors[9];

    alu_scheduler #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (req_ready != '0) begin
                checkOutput("req_ready_legal",
                            32'((req_ready & (req_ready - 1'b1)) | (req_ready & ~req_valid)), 32'd0);
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_rsp", {25'd0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = expq.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [1:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [4:0] exp);
        rsp_t e;
        bit   got;
        got    = 1'b0;
        e.id   = id[IDW-1:0];
        e.data = exp;
        expq.push_back(e);
        req_opcode[2*id +: 2] = op;
        req_a[4*id +: 4]      = a;
        req_b[4*id +: 4]      = b;
        req_valid[id]         = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid[id] = 1'b0;
            void'(expq.pop_back());
        end else begin
            checkOutput("grant_onehot", 32'(req_ready), 32'd1 << id);
            @(posedge clk);
            #1;
            req_valid[id] = 1'b0;
            checkOutput("lat_exec_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("lat_resp_valid", 32'(rsp_valid), 32'd1);
            if (rsp_ready) begin
                @(posedge clk);
                #1;
                exp_ops++;
                checkOutput("ops_done", 32'(ops_done), 32'(exp_ops));
                checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
            end
        end
    endtask

    task automatic waitDrain(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (expq.size() == 0) break;
        end
        checkOutput(name, 32'(expq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset      = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_ops = '0;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         rr_order[5];
        int         k;
        bit         got;
        logic [3:0] g;

        vectors[0] = '{2, ADD,           4'h7, 4'h7, 5'h0E};
        vectors[1] = '{1, SUB,           4'h8, 4'h7, 5'h11};
        vectors[2] = '{3, ADD,           4'h8, 4'h8, 5'h10};
        vectors[3] = '{0, NOT_A,         4'h5, 4'h0, 5'h1A};
        vectors[4] = '{2, REDUCTIONOR_B, 4'h3, 4'h0, 5'h00};
        vectors[5] = '{1, REDUCTIONOR_B, 4'h0, 4'hF, 5'h01};
        vectors[6] = '{0, SUB,           4'h7, 4'h8, 5'h0F};
        vectors[7] = '{3, ADD,           4'h7, 4'hF, 5'h06};
        vectors[8] = '{1, NOT_A,         4'h8, 4'h0, 5'h07};
        rr_order   = '{0, 1, 2, 3, 0};

        reset      = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        exp_ops    = '0;
        #2;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_ops_done", 32'(ops_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single operations and width corners");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].id, vectors[i].op, vectors[i].a, vectors[i].b, vectors[i].exp);
        end

        $display("[TB] round-robin with all requesters valid");
        applyReset();
        for (int i = 0; i < NREQ; i++) begin
            req_opcode[2*i +: 2] = ADD;
            req_a[4*i +: 4]      = 4'(i);
            req_b[4*i +: 4]      = 4'h1;
        end
        for (int i = 0; i < 5; i++) begin
            rsp_t e;
            e.id   = rr_order[i][IDW-1:0];
            e.data = 5'(rr_order[i] + 1);
            expq.push_back(e);
        end
        req_valid = '1;
        k = 0;
        for (int c = 0; c < 60 && k < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                checkOutput("rr_grant", 32'(req_ready), 32'd1 << rr_order[k]);
                k++;
                if (k == 5) begin
                    @(posedge clk);
                    #1;
                    req_valid = '0;
                end
            end
        end
        checkOutput("rr_grant_count", 32'(k), 32'd5);
        waitDrain("rr_drain");
        exp_ops = exp_ops + 16'd5;
        checkOutput("rr_ops_done", 32'(ops_done), 32'(exp_ops));

        $display("[TB] back-pressure for 10 cycles");
        rsp_ready        = 1'b0;
        req_opcode[7:6]  = SUB;
        req_a[15:12]     = 4'h2;
        req_b[15:12]     = 4'h5;
        req_valid[3]     = 1'b1;
        applyStimulus(1, ADD, 4'h3, 4'h4, 5'h07);
        begin
            rsp_t e;
            e.id   = 2'd3;
            e.data = 5'h1D;
            expq.push_back(e);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'h07);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_ops++;
        checkOutput("bp_ops_done", 32'(ops_done), 32'(exp_ops));
        checkOutput("bp_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        checkOutput("bp_single_handshake", 32'(ops_done), 32'(exp_ops));
        checkOutput("bp_no_rsp_in_exec", 32'(rsp_valid), 32'd0);
        waitDrain("bp_drain");
        exp_ops++;
        checkOutput("bp_ops_done_after", 32'(ops_done), 32'(exp_ops));

        $display("[TB] reset during EXEC");
        req_opcode[3:2] = ADD;
        req_a[7:4]      = 4'h1;
        req_b[7:4]      = 4'h1;
        req_valid[1]    = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("mid_reset_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b1;
        #1;
        checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_reset_ops_done", 32'(ops_done), 32'd0);
        checkOutput("mid_reset_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_reset_next_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_reset_next_ops", 32'(ops_done), 32'd0);
        reset   = 1'b0;
        exp_ops = '0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
        req_opcode[1:0] = SUB;
        req_a[3:0]      = 4'h3;
        req_b[3:0]      = 4'h1;
        req_opcode[5:4] = NOT_A;
        req_a[11:8]     = 4'h0;
        req_b[11:8]     = 4'h0;
        begin
            rsp_t e;
            e.id = 2'd0; e.data = 5'h02; expq.push_back(e);
            e.id = 2'd2; e.data = 5'h1F; expq.push_back(e);
        end
        req_valid = 4'b0101;
        @(negedge clk);
        g = req_ready;
        checkOutput("post_reset_winner", 32'(g), 32'd1);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g;
        for (int c = 0; c < 30 && req_valid != '0; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
        end
        waitDrain("post_reset_drain");
        exp_ops = exp_ops + 16'd2;
        checkOutput("post_reset_ops_done", 32'(ops_done), 32'(exp_ops));

        $display("[TB] ops_done wrap");
        force dut.ops_done = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.ops_done;
        #1;
        checkOutput("wrap_preload", 32'(ops_done), 32'h0000FFFF);
        exp_ops = 16'hFFFF;
        applyStimulus(2, REDUCTIONOR_B, 4'h0, 4'h1, 5'h01);
        checkOutput("wrap_to_zero", 32'(ops_done), 32'd0);
        applyStimulus(0, ADD, 4'h1, 4'h2, 5'h03);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
